led_port_bank: RTL and testbench

//  Memory-mapped multi-channel LED/GPIO output register bank; successor to the single 8-bit LED register.

---
 rtl/led_port_bank.sv | 151 +++++++++++++++
 tb/tb_led_port_bank.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/led_port_bank.sv
// led_port_bank: memory-mapped multi-channel LED/GPIO output register bank.
// Each channel register supports write/set/clear/toggle. Readback is registered,
// and bus_leds is a registered image of the channel registers.
// Optional blink engine: define LED_BLINK_EN to add per-channel blink masks,
// a free-running prescaler and a blink phase.
module led_port_bank #(
    parameter int DATA_W    = 8,
    parameter int CH_AW     = 2,
    parameter int BLINK_DIV = 25000000,
    parameter int PRESC_W   = 25
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          sel,
    input  logic                          write,
    input  logic                          read,
    input  logic [CH_AW+2:0]              addr,
    input  logic [DATA_W-1:0]             data_write,
    output logic [DATA_W-1:0]             data_read,
    output logic                          read_valid,
    output logic [DATA_W*(2**CH_AW)-1:0]  bus_leds
);

    localparam int N_CH = 2**CH_AW;

    localparam logic [2:0] OP_WRITE  = 3'b000;
    localparam logic [2:0] OP_SET    = 3'b001;
    localparam logic [2:0] OP_CLEAR  = 3'b010;
    localparam logic [2:0] OP_TOGGLE = 3'b011;
    localparam logic [2:0] OP_BLINK  = 3'b100;

    logic [CH_AW-1:0]  ch;
    logic [2:0]        op;
    logic              wr_en;
    logic              rd_en;

    logic [DATA_W-1:0] regs      [N_CH];
    logic [DATA_W-1:0] regs_next [N_CH];
    logic [DATA_W-1:0] rd_val;
    logic [DATA_W*N_CH-1:0] leds_next;

    assign ch    = addr[CH_AW+2:3];
    assign op    = addr[2:0];
    assign wr_en = sel & write;
    assign rd_en = sel & read;

    // Next value of the channel registers: only the addressed channel moves
    always_comb begin
        regs_next = regs;
        if (wr_en) begin
            case (op)
                OP_WRITE:  regs_next[ch] = data_write;
                OP_SET:    regs_next[ch] = regs[ch] | data_write;
                OP_CLEAR:  regs_next[ch] = regs[ch] & ~data_write;
                OP_TOGGLE: regs_next[ch] = regs[ch] ^ data_write;
                default:   regs_next[ch] = regs[ch];
            endcase
        end
    end

    // Channel register storage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) regs[c] <= '0;
        end else begin
            regs <= regs_next;
        end
    end

`ifdef LED_BLINK_EN
    logic [DATA_W-1:0]  masks      [N_CH];
    logic [DATA_W-1:0]  masks_next [N_CH];
    logic [PRESC_W-1:0] presc;
    logic               presc_wrap;
    logic               phase;
    logic               phase_next;

    assign presc_wrap = (presc == PRESC_W'(BLINK_DIV - 1));
    assign phase_next = presc_wrap ? ~phase : phase;

    // Next value of the blink masks
    always_comb begin
        masks_next = masks;
        if (wr_en && op == OP_BLINK) masks_next[ch] = data_write;
    end

    // Mask storage plus free-running prescaler/phase (mask writes never disturb the timebase)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) masks[c] <= '0;
            presc <= '0;
            phase <= 1'b0;
        end else begin
            masks <= masks_next;
            presc <= presc_wrap ? '0 : presc + 1'b1;
            phase <= phase_next;
        end
    end

    // LED image from next-state values so bus_leds tracks the registers after the same edge
    always_comb begin
        leds_next = '0;
        for (int c = 0; c < N_CH; c++)
            leds_next[c*DATA_W +: DATA_W] = regs_next[c] & ~(masks_next[c] & {DATA_W{phase_next}});
    end

    // Readback mux (old data: sampled from current state, not next state)
    always_comb begin
        rd_val = '0;
        case (op)
            OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE: rd_val = regs[ch];
            OP_BLINK:                              rd_val = masks[ch];
            default:                               rd_val = '0;
        endcase
    end
`else
    // LED image is the plain register contents
    always_comb begin
        leds_next = '0;
        for (int c = 0; c < N_CH; c++)
            leds_next[c*DATA_W +: DATA_W] = regs_next[c];
    end

    // Readback mux (old data: sampled from current state, not next state)
    always_comb begin
        rd_val = '0;
        case (op)
            OP_WRITE, OP_SET, OP_CLEAR, OP_TOGGLE: rd_val = regs[ch];
            default:                               rd_val = '0;
        endcase
    end
`endif

    // Registered LED output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) bus_leds <= '0;
        else     bus_leds <= leds_next;
    end

    // Registered readback; data_read holds until the next accepted read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_read  <= '0;
            read_valid <= 1'b0;
        end else begin
            read_valid <= rd_en;
            if (rd_en) data_read <= rd_val;
        end
    end

endmodule

// File: tb/tb_led_port_bank.sv
// Bench for led_port_bank (DATA_W=8, CH_AW=2, BLINK_DIV=4). Works with or
// without LED_BLINK_EN defined.
module tb_led_port_bank;

    localparam int DATA_W = 8;
    localparam int CH_AW  = 2;
    localparam int DIV    = 4;
    localparam int N_CH   = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        write = 1'b0;
    logic        read = 1'b0;
    logic [4:0]  addr = '0;
    logic [7:0]  data_write = '0;
    logic [7:0]  data_read;
    logic        read_valid;
    logic [31:0] bus_leds;

    int passed = 0;
    int total  = 0;

    led_port_bank #(.DATA_W(DATA_W), .CH_AW(CH_AW), .BLINK_DIV(DIV), .PRESC_W(3)) dut (
        .clk(clk), .rst(rst), .sel(sel), .write(write), .read(read), .addr(addr),
        .data_write(data_write), .data_read(data_read), .read_valid(read_valid),
        .bus_leds(bus_leds)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        else passed++;
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] m_reg  [N_CH];
    logic [7:0] m_mask [N_CH];
    int         m_edges;
    logic [7:0] m_rd;
    logic       m_rv;

    function automatic logic [31:0] exp_leds();
        logic [31:0] v;
        logic [7:0]  r;
        v = '0;
        for (int c = 0; c < N_CH; c++) begin
            r = m_reg[c];
`ifdef LED_BLINK_EN
            if (((m_edges / DIV) % 2) == 1) r = r & ~m_mask[c];
`endif
            v[c*8 +: 8] = r;
        end
        return v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < N_CH; c++) begin
                m_reg[c]  = '0;
                m_mask[c] = '0;
            end
            m_edges = 0;
            m_rd    = '0;
            m_rv    = 1'b0;
        end else begin
            m_edges = m_edges + 1;
            m_rv = sel && read;
            if (sel && read) begin
                case (addr[2:0])
                    3'd0, 3'd1, 3'd2, 3'd3: m_rd = m_reg[addr[4:3]];
`ifdef LED_BLINK_EN
                    3'd4: m_rd = m_mask[addr[4:3]];
`endif
                    default: m_rd = 8'h00;
                endcase
            end
            if (sel && write) begin
                case (addr[2:0])
                    3'd0: m_reg[addr[4:3]] = data_write;
                    3'd1: m_reg[addr[4:3]] = m_reg[addr[4:3]] | data_write;
                    3'd2: m_reg[addr[4:3]] = m_reg[addr[4:3]] & ~data_write;
                    3'd3: m_reg[addr[4:3]] = m_reg[addr[4:3]] ^ data_write;
`ifdef LED_BLINK_EN
                    3'd4: m_mask[addr[4:3]] = data_write;
`endif
                    default: ;
                endcase
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("cyc_bus_leds", bus_leds, exp_leds());
        check("cyc_read_valid", {31'b0, read_valid}, {31'b0, m_rv});
        check("cyc_data_read", {24'b0, data_read}, {24'b0, m_rd});
    end

    // ---------------- stimulus ----------------
    task automatic idle();
        sel = 1'b0; write = 1'b0; read = 1'b0; addr = '0; data_write = '0;
    endtask

    task automatic wr(input logic [1:0] ch, input logic [2:0] op, input logic [7:0] d);
        sel = 1'b1; write = 1'b1; read = 1'b0; addr = {ch, op}; data_write = d;
        @(posedge clk); #1;
        idle();
    endtask

    task automatic rd(input string name, input logic [1:0] ch, input logic [2:0] op, input logic [7:0] exp);
        sel = 1'b1; write = 1'b0; read = 1'b1; addr = {ch, op};
        @(posedge clk); #1;
        idle();
        check({name, "_data"}, {24'b0, data_read}, {24'b0, exp});
        check({name, "_valid"}, {31'b0, read_valid}, 32'd1);
        @(posedge clk); #1;
        check({name, "_pulse_end"}, {31'b0, read_valid}, 32'd0);
        check({name, "_hold"}, {24'b0, data_read}, {24'b0, exp});
    endtask

    int n_ff, n_f0;

    initial begin
        idle();
        #22 rst = 1'b0;
        @(posedge clk); #1;
        check("reset_leds", bus_leds, 32'h0);
        check("reset_rv", {31'b0, read_valid}, 32'd0);

        // WRITE ch2 = A5
        wr(2'd2, 3'b000, 8'hA5);
        check("wr_ch2_leds", bus_leds, 32'h00A50000);
        rd("rd_ch2", 2'd2, 3'b000, 8'hA5);

        // ch1 set/clear/toggle
        wr(2'd1, 3'b000, 8'hF0);
        wr(2'd1, 3'b001, 8'h0F);
        rd("rd_set", 2'd1, 3'b000, 8'hFF);
        wr(2'd1, 3'b010, 8'h3C);
        rd("rd_clear", 2'd1, 3'b001, 8'hC3);
        wr(2'd1, 3'b011, 8'hFF);
        rd("rd_toggle", 2'd1, 3'b011, 8'h3C);
        check("others_hold", bus_leds, 32'h00A53C00);

        // Simultaneous write + read on ch3 returns old data
        wr(2'd3, 3'b000, 8'h12);
        sel = 1'b1; write = 1'b1; read = 1'b1; addr = {2'd3, 3'b000}; data_write = 8'h55;
        @(posedge clk); #1;
        idle();
        check("rw_old_data", {24'b0, data_read}, 32'h12);
        check("rw_leds", bus_leds, 32'h55A53C00);
        rd("rd_new", 2'd3, 3'b000, 8'h55);

        // sel=0 write and reserved op write are ignored
        sel = 1'b0; write = 1'b1; addr = {2'd1, 3'b000}; data_write = 8'h00;
        @(posedge clk); #1;
        idle();
        wr(2'd1, 3'b110, 8'hAA);
        check("ignored_leds", bus_leds, 32'h55A53C00);
        rd("rd_op110", 2'd1, 3'b110, 8'h00);
        rd("rd_ch1_kept", 2'd1, 3'b000, 8'h3C);
        // sel=0 read gives no pulse
        sel = 1'b0; read = 1'b1; addr = {2'd1, 3'b000};
        @(posedge clk); #1;
        idle();
        check("nosel_rv", {31'b0, read_valid}, 32'd0);

        // Asynchronous reset mid-run, right after a read pulse
        sel = 1'b1; read = 1'b1; addr = {2'd2, 3'b000};
        @(posedge clk); #1;
        idle();
        check("pre_rst_rv", {31'b0, read_valid}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_leds", bus_leds, 32'h0);
        check("async_rst_rv", {31'b0, read_valid}, 32'd0);
        check("async_rst_data", {24'b0, data_read}, 32'h0);
        @(posedge clk); #3 rst = 1'b0;

        // Blink: ch0 = FF, mask = 0F
        @(posedge clk); #1;
        wr(2'd0, 3'b000, 8'hFF);
        wr(2'd0, 3'b100, 8'h0F);
`ifdef LED_BLINK_EN
        rd("rd_mask", 2'd0, 3'b100, 8'h0F);
`else
        rd("rd_mask", 2'd0, 3'b100, 8'h00);
`endif
        n_ff = 0; n_f0 = 0;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            if (bus_leds[7:0] == 8'hFF) n_ff++;
            else if (bus_leds[7:0] == 8'hF0) n_f0++;
        end
`ifdef LED_BLINK_EN
        check("blink_ff_count", n_ff, 32'd8);
        check("blink_f0_count", n_f0, 32'd8);
`else
        check("steady_ff_count", n_ff, 32'd16);
        check("steady_f0_count", n_f0, 32'd0);
`endif
        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
